// File: rtl/ddram_arb_pkg.sv
// Shared types for the DDR3 ROM/save-store arbiter.
package ddram_arb_pkg;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {SYNC, IDLE, WR, RD} state_t;
  typedef enum logic [1:0] {P_DL, P_ROM, P_SV} port_t;
endpackage

// File: rtl/ddram_arb_pick.sv
// Combinational grant selector: dl first, then rom/sv round-robin.
// The sv leg only exists when DDRAM_SAVE_PORT_EN is defined.
module ddram_arb_pick
  import ddram_arb_pkg::*;
(
  input  logic       dl_pend,
  input  logic       rom_pend,
  input  logic       sv_pend,
  input  logic       dl_active,
  input  logic       last_sv,
  output logic       valid,
  output logic [1:0] port
);
  logic rom_ok;

  always_comb begin
    rom_ok = rom_pend & ~dl_active;
    valid  = 1'b1;
    port   = P_DL;
`ifdef DDRAM_SAVE_PORT_EN
    if (dl_pend)                port = P_DL;
    else if (rom_ok && sv_pend) port = last_sv ? P_ROM : P_SV;
    else if (rom_ok)            port = P_ROM;
    else if (sv_pend)           port = P_SV;
    else                        valid = 1'b0;
`else
    if (dl_pend)     port = P_DL;
    else if (rom_ok) port = P_ROM;
    else             valid = 1'b0;
`endif
  end

`ifndef DDRAM_SAVE_PORT_EN
  logic unused_sv;
  assign unused_sv = sv_pend ^ last_sv;
`endif
endmodule

// File: rtl/ddram_arbiter.sv
// Single-outstanding scheduler between ddram toggle ports and dl/rom/sv requesters.
// Save port and round-robin are built only when DDRAM_SAVE_PORT_EN is defined.
module ddram_arbiter
  import ddram_arb_pkg::*;
#(
  parameter logic [7:0] SAVE_BASE   = 8'hF8,
  parameter int         SYNC_CYCLES = 64
)(
  input  logic              MCLK,
  input  logic              RESET_N,
  input  logic              dl_active,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_din,
  input  logic              dl_req,
  output logic              dl_ack,
  input  logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_req,
  output logic              rom_ack,
  output logic [DATA_W-1:0] rom_dout,
  input  logic [15:0]       sv_addr,
  input  logic [DATA_W-1:0] sv_din,
  input  logic              sv_we,
  input  logic              sv_req,
  output logic              sv_ack,
  output logic [DATA_W-1:0] sv_dout,
  output logic [ADDR_W-1:0] mem_wraddr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we_req,
  input  logic              mem_we_ack,
  output logic [ADDR_W-1:0] mem_rdaddr,
  output logic              mem_rd_req,
  input  logic              mem_rd_ack,
  input  logic [DATA_W-1:0] mem_dout
);
  localparam int CNT_W = $clog2(SYNC_CYCLES + 1);

  state_t           state;
  port_t            gnt;
  logic [CNT_W-1:0] cnt;
  logic             pick_vld;
  logic [1:0]       pick_id;
  logic             sv_pend;
  logic             last_sv_q;

`ifdef DDRAM_SAVE_PORT_EN
  logic              last_sv;
  logic              sv_ack_r;
  logic [DATA_W-1:0] sv_dout_r;
  assign sv_pend   = sv_req != sv_ack_r;
  assign last_sv_q = last_sv;
  assign sv_ack    = sv_ack_r;
  assign sv_dout   = sv_dout_r;
`else
  logic unused_sv;
  assign unused_sv = ^{SAVE_BASE, sv_addr, sv_din, sv_we, sv_req};
  assign sv_pend   = 1'b0;
  assign last_sv_q = 1'b0;
  assign sv_ack    = 1'b0;
  assign sv_dout   = '0;
`endif

  ddram_arb_pick u_pick (
    .dl_pend  (dl_req != dl_ack),
    .rom_pend (rom_req != rom_ack),
    .sv_pend  (sv_pend),
    .dl_active(dl_active),
    .last_sv  (last_sv_q),
    .valid    (pick_vld),
    .port     (pick_id)
  );

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= SYNC;
      cnt        <= '0;
      gnt        <= P_DL;
      dl_ack     <= 1'b0;
      rom_ack    <= 1'b0;
      rom_dout   <= '0;
      mem_wraddr <= '0;
      mem_rdaddr <= '0;
      mem_din    <= '0;
      mem_we_req <= 1'b0;
      mem_rd_req <= 1'b0;
`ifdef DDRAM_SAVE_PORT_EN
      last_sv    <= 1'b0;
      sv_ack_r   <= 1'b0;
      sv_dout_r  <= '0;
`endif
    end else begin
      case (state)
        // Shadow downstream acks so a transaction cut short by reset is absorbed.
        SYNC: begin
          mem_we_req <= mem_we_ack;
          mem_rd_req <= mem_rd_ack;
          cnt        <= cnt + 1'b1;
          if (cnt == CNT_W'(SYNC_CYCLES - 1)) state <= IDLE;
        end
        IDLE: if (pick_vld) begin
          gnt <= port_t'(pick_id);
          case (port_t'(pick_id))
            P_DL: begin
              mem_wraddr <= dl_addr;
              mem_din    <= dl_din;
              mem_we_req <= ~mem_we_req;
              state      <= WR;
            end
            P_ROM: begin
              mem_rdaddr <= rom_addr;
              mem_rd_req <= ~mem_rd_req;
              state      <= RD;
`ifdef DDRAM_SAVE_PORT_EN
              last_sv    <= 1'b0;
`endif
            end
`ifdef DDRAM_SAVE_PORT_EN
            P_SV: begin
              last_sv <= 1'b1;
              if (sv_we) begin
                mem_wraddr <= {SAVE_BASE, sv_addr};
                mem_din    <= sv_din;
                mem_we_req <= ~mem_we_req;
                state      <= WR;
              end else begin
                mem_rdaddr <= {SAVE_BASE, sv_addr};
                mem_rd_req <= ~mem_rd_req;
                state      <= RD;
              end
            end
`endif
            default: ;
          endcase
        end
        WR: if (mem_we_ack == mem_we_req) begin
          case (gnt)
            P_DL: dl_ack <= ~dl_ack;
`ifdef DDRAM_SAVE_PORT_EN
            P_SV: sv_ack_r <= ~sv_ack_r;
`endif
            default: ;
          endcase
          state <= IDLE;
        end
        RD: if (mem_rd_ack == mem_rd_req) begin
          case (gnt)
            P_ROM: begin
              rom_dout <= mem_dout;
              rom_ack  <= ~rom_ack;
            end
`ifdef DDRAM_SAVE_PORT_EN
            P_SV: begin
              sv_dout_r <= mem_dout;
              sv_ack_r  <= ~sv_ack_r;
            end
`endif
            default: ;
          endcase
          state <= IDLE;
        end
        default: state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_ddram_arbiter.sv
// Directed bench for ddram_arbiter: ddram toggle model plus grant scoreboard.
// Save-port steps run only when DDRAM_SAVE_PORT_EN is defined.
module tb_ddram_arbiter;
  localparam int LAT = 2;

  logic        MCLK = 1'b0, RESET_N = 1'b0;
  logic        dl_active = 1'b0, dl_req = 1'b0, rom_req = 1'b0, sv_req = 1'b0, sv_we = 1'b0;
  logic [23:0] dl_addr = '0, rom_addr = '0;
  logic [15:0] dl_din = '0, sv_addr = '0, sv_din = '0;
  logic        dl_ack, rom_ack, sv_ack, mem_we_req, mem_rd_req;
  logic [15:0] rom_dout, sv_dout, mem_din;
  logic [23:0] mem_wraddr, mem_rdaddr;
  logic        mem_we_ack = 1'b0, mem_rd_ack = 1'b0;
  logic [15:0] mem_dout = '0;

  typedef struct { logic we; logic [23:0] addr; logic [15:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] mem_model [logic [23:0]];
  int          n_assert = 0, n_fail = 0;
  logic        auto_ack = 1'b0, mon_en = 1'b0, man_we = 1'b0, man_rd = 1'b0;

  always #5 MCLK = ~MCLK;

  ddram_arbiter #(.SAVE_BASE(8'hF8), .SYNC_CYCLES(64)) dut (
    .MCLK(MCLK), .RESET_N(RESET_N), .dl_active(dl_active),
    .dl_addr(dl_addr), .dl_din(dl_din), .dl_req(dl_req), .dl_ack(dl_ack),
    .rom_addr(rom_addr), .rom_req(rom_req), .rom_ack(rom_ack), .rom_dout(rom_dout),
    .sv_addr(sv_addr), .sv_din(sv_din), .sv_we(sv_we), .sv_req(sv_req),
    .sv_ack(sv_ack), .sv_dout(sv_dout),
    .mem_wraddr(mem_wraddr), .mem_din(mem_din), .mem_we_req(mem_we_req), .mem_we_ack(mem_we_ack),
    .mem_rdaddr(mem_rdaddr), .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack), .mem_dout(mem_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] rd_val(input logic [23:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic void push_wr(input logic [23:0] a, input logic [15:0] d);
    exp_t e;
    e.we = 1'b1; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void push_rd(input logic [23:0] a);
    exp_t e;
    e.we = 1'b0; e.addr = a; e.data = '0;
    exp_q.push_back(e);
  endfunction

  function automatic logic pend(input int p);
    case (p)
      0:       return dl_req != dl_ack;
      1:       return rom_req != rom_ack;
      default: return sv_req != sv_ack;
    endcase
  endfunction

  task automatic wait_port(input int p, input string tag);
    int c = 0;
    while (pend(p) && c < 200) begin @(posedge MCLK); #1; c++; end
    chk(tag, 32'(pend(p)), 0);
  endtask

  task automatic grant_seen(input logic we);
    exp_t e;
    chk("grant expected", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("grant kind", 32'(we), 32'(e.we));
      if (we) begin
        chk("grant wr addr", 32'(mem_wraddr), 32'(e.addr));
        chk("grant wr data", 32'(mem_din), 32'(e.data));
      end else
        chk("grant rd addr", 32'(mem_rdaddr), 32'(e.addr));
    end
  endtask

  // ddram model: acks after LAT cycles in auto mode, else mirrors man_* values
  initial begin
    int wc = 0, rc = 0;
    forever begin
      @(posedge MCLK); #2;
      if (!auto_ack) begin
        mem_we_ack = man_we;
        mem_rd_ack = man_rd;
        wc = 0; rc = 0;
      end else begin
        if (mem_we_req !== mem_we_ack) begin
          if (wc >= LAT) begin
            mem_model[mem_wraddr] = mem_din;
            mem_we_ack = mem_we_req; wc = 0;
          end else wc++;
        end else wc = 0;
        if (mem_rd_req !== mem_rd_ack) begin
          if (rc >= LAT) begin
            mem_dout = rd_val(mem_rdaddr);
            mem_rd_ack = mem_rd_req; rc = 0;
          end else rc++;
        end else rc = 0;
      end
    end
  end

  // grant monitor: every mem toggle pops one scoreboard entry
  initial begin
    logic pw = 1'b0, pr = 1'b0;
    forever begin
      @(negedge MCLK);
      if (mon_en && mem_we_req !== pw) grant_seen(1'b1);
      if (mon_en && mem_rd_req !== pr) grant_seen(1'b0);
      pw = mem_we_req;
      pr = mem_rd_req;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sr, tgt, rd_tgt;
    int   bad, cyc, nrom, nsv, crom, csv;

    // reset values
    repeat (3) @(posedge MCLK);
    #1;
    chk("rst dl_ack", 32'(dl_ack), 0);
    chk("rst rom_ack", 32'(rom_ack), 0);
    chk("rst sv_ack", 32'(sv_ack), 0);
    chk("rst rom_dout", 32'(rom_dout), 0);
    chk("rst sv_dout", 32'(sv_dout), 0);
    chk("rst mem reqs", 32'({mem_we_req, mem_rd_req}), 0);
    chk("rst mem_wraddr", 32'(mem_wraddr), 0);
    chk("rst mem_rdaddr", 32'(mem_rdaddr), 0);
    chk("rst mem_din", 32'(mem_din), 0);

    // SYNC follows acks held at 1, and blocks the pending dl write for 64 cycles
    man_we = 1'b1; man_rd = 1'b1;
    repeat (2) @(posedge MCLK);
    #1 RESET_N = 1'b1;
    dl_addr = 24'h000100; dl_din = 16'hA55A; dl_req = 1'b1;
    push_wr(24'h000100, 16'hA55A);
    @(posedge MCLK); #1;
    chk("sync we_req follows", 32'(mem_we_req), 1);
    chk("sync rd_req follows", 32'(mem_rd_req), 1);
    bad = 0;
    for (int i = 2; i <= 64; i++) begin
      @(posedge MCLK); #1;
      if (mem_wraddr !== 24'h0 || dl_ack !== 1'b0 || mem_we_req !== 1'b1) bad++;
    end
    chk("no grant during sync", 32'(bad), 0);
    mon_en = 1'b1;
    @(posedge MCLK); #1;
    chk("dl grant at sync exit", 32'(mem_we_req), 0);
    chk("dl wraddr", 32'(mem_wraddr), 32'h000100);
    chk("dl din", 32'(mem_din), 32'hA55A);
    repeat (2) @(posedge MCLK);
    #1 man_we = 1'b0;
    chk("dl ack not early", 32'(dl_ack), 0);
    @(posedge MCLK); #1;
    chk("dl ack one cycle after mem ack", 32'(dl_ack), 1);
    auto_ack = 1'b1;

    // dl write latency: toggle appears on the first edge after the request
    dl_addr = 24'h0ABCDE; dl_din = 16'h1357;
    push_wr(24'h0ABCDE, 16'h1357);
    tgt = ~mem_we_req;
    dl_req = ~dl_req;
    @(posedge MCLK); #1;
    chk("dl grant latency", 32'(mem_we_req), 32'(tgt));
    wait_port(0, "dl write 2 done");

    // rom blocked by dl_active
    dl_active = 1'b1;
    rom_addr = 24'h000200;
    push_rd(24'h000200);
    sr = mem_rd_req;
    rom_req = ~rom_req;
    bad = 0;
    repeat (10) begin @(posedge MCLK); #1; if (mem_rd_req !== sr) bad++; end
    chk("rom blocked by dl_active", 32'(bad), 0);
    dl_active = 1'b0;
    tgt = ~sr;
    @(posedge MCLK); #1;
    chk("rom issues after dl_active", 32'(mem_rd_req), 32'(tgt));
    wait_port(1, "rom read 200 done");
    chk("rom dout 200", 32'(rom_dout), 32'(rd_val(24'h000200)));

    // read data lands on the same edge as the ack toggle
    mem_model[24'h000300] = 16'h1234;
    rom_addr = 24'h000300;
    push_rd(24'h000300);
    rom_req = ~rom_req;
    bad = 0; cyc = 0;
    while (pend(1) && cyc < 100) begin
      if (rom_dout === 16'h1234) bad++;
      @(posedge MCLK); #1; cyc++;
    end
    chk("rom dout not early", 32'(bad), 0);
    chk("rom read 300 done", 32'(pend(1)), 0);
    chk("rom dout with ack", 32'(rom_dout), 32'h1234);

    // dl beats rom when both pending
    dl_addr = 24'h000777; dl_din = 16'h0F0F; rom_addr = 24'h000310;
    push_wr(24'h000777, 16'h0F0F);
    push_rd(24'h000310);
    dl_req = ~dl_req; rom_req = ~rom_req;
    wait_port(0, "prio dl done");
    wait_port(1, "prio rom done");
    chk("prio rom dout", 32'(rom_dout), 32'(rd_val(24'h000310)));

`ifdef DDRAM_SAVE_PORT_EN
    // sv write, read back, then rom/sv alternation
    sv_we = 1'b1; sv_addr = 16'h0020; sv_din = 16'hBEEF;
    push_wr(24'hF80020, 16'hBEEF);
    sv_req = ~sv_req;
    wait_port(2, "sv write done");
    sv_we = 1'b0;
    push_rd(24'hF80020);
    sv_req = ~sv_req;
    wait_port(2, "sv read done");
    chk("sv readback", 32'(sv_dout), 32'hBEEF);

    for (int k = 0; k < 3; k++) begin
      push_rd(24'(32'h000400 + k));
      push_rd(24'(32'hF80010 + k));
    end
    rom_addr = 24'h000400; sv_addr = 16'h0010;
    rom_req = ~rom_req; sv_req = ~sv_req;
    nrom = 1; nsv = 1; crom = 0; csv = 0; cyc = 0;
    while ((crom < 3 || csv < 3) && cyc < 400) begin
      @(posedge MCLK); #1; cyc++;
      if (rom_ack === rom_req && crom < nrom) begin
        chk("rr rom dout", 32'(rom_dout), 32'(rd_val(24'(32'h000400 + crom))));
        crom++;
        if (nrom < 3) begin rom_addr = 24'(32'h000400 + nrom); nrom++; rom_req = ~rom_req; end
      end
      if (sv_ack === sv_req && csv < nsv) begin
        chk("rr sv dout", 32'(sv_dout), 32'(rd_val(24'(32'hF80010 + csv))));
        csv++;
        if (nsv < 3) begin sv_addr = 16'(32'h0010 + nsv); nsv++; sv_req = ~sv_req; end
      end
    end
    chk("rr completions", 32'(crom + csv), 6);
`else
    // save port inert: no ack, no data, no grant
    sr = mem_rd_req; tgt = mem_we_req;
    sv_addr = 16'h0010; sv_req = 1'b1;
    repeat (20) @(posedge MCLK);
    #1;
    chk("sv ignored ack", 32'(sv_ack), 0);
    chk("sv ignored dout", 32'(sv_dout), 0);
    chk("sv ignored mem", 32'({mem_rd_req, mem_we_req}), 32'({sr, tgt}));
    sv_req = 1'b0;
`endif

    // reset while in RD; late ack absorbed by SYNC
    man_we = mem_we_ack; man_rd = mem_rd_ack;
    auto_ack = 1'b0;
    rom_addr = 24'h000500;
    push_rd(24'h000500);
    sr = mem_rd_req;
    rom_req = ~rom_req;
    @(posedge MCLK); #1;
    rd_tgt = ~sr;
    chk("rd issued before reset", 32'(mem_rd_req), 32'(rd_tgt));
    repeat (2) @(posedge MCLK);
    #1 mon_en = 1'b0;
    RESET_N = 1'b0;
    dl_req = 1'b0; rom_req = 1'b0; sv_req = 1'b0;
    #1;
    chk("mid-rd reset rom_dout", 32'(rom_dout), 0);
    chk("mid-rd reset rd_req", 32'(mem_rd_req), 0);
    @(posedge MCLK);
    #1 RESET_N = 1'b1;
    bad = 0;
    for (int c = 1; c <= 64; c++) begin
      @(posedge MCLK); #1;
      if (c == 10) man_rd = rd_tgt;
      if (dl_ack !== 1'b0 || rom_ack !== 1'b0 || sv_ack !== 1'b0) bad++;
    end
    chk("no port ack after reset", 32'(bad), 0);
    chk("rd toggles aligned at sync exit", 32'(mem_rd_req), 32'(mem_rd_ack));
    chk("we toggles aligned at sync exit", 32'(mem_we_req), 32'(mem_we_ack));
    mon_en = 1'b1;
    auto_ack = 1'b1;
    rom_addr = 24'h000600;
    push_rd(24'h000600);
    rom_req = ~rom_req;
    wait_port(1, "rom read after reset done");
    chk("rom dout after reset", 32'(rom_dout), 32'(rd_val(24'h000600)));

    repeat (3) @(posedge MCLK);
    #1;
    chk("scoreboard drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
